// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request path.
// Holds the floor index width, the request record and the reject reason
// codes. Imported by the request queue and by the downstream controller.
package elevator_pkg;

  localparam int FLOOR_W = 3;

  typedef struct packed {
    logic [FLOOR_W-1:0] src;
    logic [FLOOR_W-1:0] dest;
    logic               dir;
  } req_t;

  localparam logic [1:0] REJ_NONE    = 2'd0;
  localparam logic [1:0] REJ_INVALID = 2'd1;
  localparam logic [1:0] REJ_DUP     = 2'd2;
  localparam logic [1:0] REJ_FULL    = 2'd3;

endpackage

// File: rtl/req_fifo.sv
// Generic in-order register FIFO with parallel visibility of every slot.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (pointers/count only)
//   push, pop    enqueue wr_data at tail / drop head; ignored when illegal
//   wr_data      entry to write
//   rd_data      head entry (stale when count == 0)
//   entries      raw contents of all slots, indexed by physical slot
//   slot_valid   per physical slot: slot currently holds a live entry
//   head_ptr     physical slot of the head
//   count, full  occupancy
module req_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic [DEPTH-1:0][WIDTH-1:0]    entries,
  output logic [DEPTH-1:0]               slot_valid,
  output logic [$clog2(DEPTH)-1:0]       head_ptr,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic                        push_ok;
  logic                        pop_ok;
  logic                        empty;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A push into a full FIFO is legal when the head leaves in the same cycle:
  // the freed slot is exactly the one the tail pointer addresses.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Contents are deliberately not reset; liveness comes from count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    slot_valid = '0;
    off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off           = PTR_W'(i) - rd_ptr;
      slot_valid[i] = ({1'b0, off} < count);
    end
  end

  assign entries  = mem;
  assign rd_data  = mem[rd_ptr];
  assign head_ptr = rd_ptr;

endmodule

// File: rtl/elevator_request_queue.sv
// Request capture stage ahead of the elevator controller.
// Validates call-panel strobes, drops duplicates of requests already queued,
// buffers accepted requests in order and offers the oldest over valid/ready.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_stb/src/dest/dir        one-cycle request from the call panel
//   out_valid/ready             head handshake to the controller
//   out_src/dest/dir            head request, zero while out_valid = 0
//   count, full                 occupancy
//   reject, reject_code         one-cycle pulse for a strobe not enqueued
module elevator_request_queue #(
  parameter int FLOOR_W = elevator_pkg::FLOOR_W,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_stb,
  input  logic [FLOOR_W-1:0]       req_src,
  input  logic [FLOOR_W-1:0]       req_dest,
  input  logic                     req_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLOOR_W-1:0]       out_src,
  output logic [FLOOR_W-1:0]       out_dest,
  output logic                     out_dir,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     reject,
  output logic [1:0]               reject_code
);

  import elevator_pkg::*;

  localparam int ENTRY_W = 2 * FLOOR_W + 1;
  localparam int PTR_W   = $clog2(DEPTH);

  logic [ENTRY_W-1:0]              new_entry;
  logic [ENTRY_W-1:0]              head;
  logic [DEPTH-1:0][ENTRY_W-1:0]   entries;
  logic [DEPTH-1:0]                slot_valid;
  logic [PTR_W-1:0]                head_ptr;
  logic                            pop;
  logic                            req_bad;
  logic                            dup;
  logic                            accept;
  logic [1:0]                      rej_code;

  assign new_entry = {req_src, req_dest, req_dir};
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // A request is coherent only if it moves and its direction flag agrees
  // with the sign of the move.
  assign req_bad = (req_src == req_dest) || (req_dir != (req_dest > req_src));

  // The head leaving this cycle no longer counts as held, so the same
  // request may be re-queued behind it.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && !(pop && (PTR_W'(i) == head_ptr)) &&
          (entries[i] == new_entry))
        dup = 1'b1;
    end
  end

  always_comb begin
    rej_code = REJ_NONE;
    if (req_bad)            rej_code = REJ_INVALID;
    else if (dup)           rej_code = REJ_DUP;
    else if (full && !pop)  rej_code = REJ_FULL;
  end

  assign accept = req_stb && (rej_code == REJ_NONE);

  req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .pop        (pop),
    .wr_data    (new_entry),
    .rd_data    (head),
    .entries    (entries),
    .slot_valid (slot_valid),
    .head_ptr   (head_ptr),
    .count      (count),
    .full       (full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reject      <= 1'b0;
      reject_code <= REJ_NONE;
    end else begin
      reject      <= req_stb && (rej_code != REJ_NONE);
      reject_code <= req_stb ? rej_code : REJ_NONE;
    end
  end

  // Stale slot contents survive reset, so mask the head until it is live.
  assign out_src  = out_valid ? head[ENTRY_W-1 -: FLOOR_W] : '0;
  assign out_dest = out_valid ? head[FLOOR_W -: FLOOR_W]   : '0;
  assign out_dir  = out_valid ? head[0]                    : 1'b0;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for elevator_request_queue with a queue scoreboard of
// accepted requests; occupancy, head contents and reject pulses are checked
// every cycle against it.
module tb_elevator_request_queue;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_stb;
  logic [2:0] req_src;
  logic [2:0] req_dest;
  logic       req_dir;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_src;
  logic [2:0] out_dest;
  logic       out_dir;
  logic [2:0] count;
  logic       full;
  logic       reject;
  logic [1:0] reject_code;

  int   checks = 0;
  int   errors = 0;
  req_t sb[$];

  elevator_request_queue #(.FLOOR_W(3), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_stb     (req_stb),
    .req_src     (req_src),
    .req_dest    (req_dest),
    .req_dir     (req_dir),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_src     (out_src),
    .out_dest    (out_dest),
    .out_dir     (out_dir),
    .count       (count),
    .full        (full),
    .reject      (reject),
    .reject_code (reject_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    int n;
    n = sb.size();
    chk({tag, " count"}, 8'(count), 8'(n));
    chk({tag, " out_valid"}, 8'(out_valid), 8'(n != 0));
    chk({tag, " full"}, 8'(full), 8'(n == 4));
    if (n != 0) begin
      chk({tag, " out_src"}, 8'(out_src), 8'(sb[0].src));
      chk({tag, " out_dest"}, 8'(out_dest), 8'(sb[0].dest));
      chk({tag, " out_dir"}, 8'(out_dir), 8'(sb[0].dir));
    end else begin
      chk({tag, " out_src idle"}, 8'(out_src), 8'h0);
      chk({tag, " out_dest idle"}, 8'(out_dest), 8'h0);
      chk({tag, " out_dir idle"}, 8'(out_dir), 8'h0);
    end
  endtask

  // One clock: drive the inputs, update the scoreboard with the intended
  // outcome, then check pulse and state one time unit after the edge.
  task automatic cycle(input string tag, input logic stb, input logic [2:0] s,
                       input logic [2:0] d, input logic dir, input logic rdy,
                       input logic [1:0] exp_code);
    req_t r;
    req_stb   = stb;
    req_src   = s;
    req_dest  = d;
    req_dir   = dir;
    out_ready = rdy;
    if (rdy && sb.size() != 0) void'(sb.pop_front());
    if (stb && exp_code == REJ_NONE) begin
      r.src  = s;
      r.dest = d;
      r.dir  = dir;
      sb.push_back(r);
    end
    @(posedge clk);
    #1;
    req_stb = 1'b0;
    out_ready = 1'b0;
    chk({tag, " reject"}, 8'(reject), 8'(stb && exp_code != REJ_NONE));
    chk({tag, " reject_code"}, 8'(reject_code), 8'(stb ? exp_code : REJ_NONE));
    chk_state(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_stb   = 1'b0;
    req_src   = '0;
    req_dest  = '0;
    req_dir   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst reject", 8'(reject), 8'h0);
    chk("rst reject_code", 8'(reject_code), 8'h0);
    chk_state("rst");
    rst_n = 1'b1;

    // First request appears with one cycle of latency.
    cycle("first 2->5", 1, 3'd2, 3'd5, 1, 0, REJ_NONE);

    // Incoherent requests.
    cycle("inv 3->3", 1, 3'd3, 3'd3, 1, 0, REJ_INVALID);
    cycle("inv 4->3 up", 1, 3'd4, 3'd3, 1, 0, REJ_INVALID);
    cycle("inv 1->6 down", 1, 3'd1, 3'd6, 0, 0, REJ_INVALID);
    cycle("gap", 0, 3'd0, 3'd0, 0, 0, REJ_NONE);

    // Duplicate of the held head, then the same request while the head pops.
    cycle("dup 2->5", 1, 3'd2, 3'd5, 1, 0, REJ_DUP);
    cycle("dup w/ pop", 1, 3'd2, 3'd5, 1, 1, REJ_NONE);
    cycle("drain a", 0, 3'd0, 3'd0, 0, 1, REJ_NONE);
    cycle("ready empty", 0, 3'd0, 3'd0, 0, 1, REJ_NONE);

    // Fill, full reject, duplicate priority over full, full with pop.
    cycle("fill 1->2", 1, 3'd1, 3'd2, 1, 0, REJ_NONE);
    cycle("fill 2->3", 1, 3'd2, 3'd3, 1, 0, REJ_NONE);
    cycle("fill 3->4", 1, 3'd3, 3'd4, 1, 0, REJ_NONE);
    cycle("fill 4->5", 1, 3'd4, 3'd5, 1, 0, REJ_NONE);
    cycle("full 5->6", 1, 3'd5, 3'd6, 1, 0, REJ_FULL);
    cycle("full dup 3->4", 1, 3'd3, 3'd4, 1, 0, REJ_DUP);
    cycle("full inv 6->6", 1, 3'd6, 3'd6, 1, 0, REJ_INVALID);
    cycle("full pop 5->6", 1, 3'd5, 3'd6, 1, 1, REJ_NONE);
    for (int i = 0; i < 5; i++) cycle("drain b", 0, 3'd0, 3'd0, 0, 1, REJ_NONE);

    // Interleaved pushes and pops crossing the pointer wrap.
    cycle("wrap 6->1", 1, 3'd6, 3'd1, 0, 0, REJ_NONE);
    cycle("wrap 7->0", 1, 3'd7, 3'd0, 0, 1, REJ_NONE);
    cycle("wrap 0->7", 1, 3'd0, 3'd7, 1, 0, REJ_NONE);
    cycle("wrap 5->2", 1, 3'd5, 3'd2, 0, 1, REJ_NONE);
    cycle("wrap 1->6", 1, 3'd1, 3'd6, 1, 0, REJ_NONE);
    cycle("wrap 3->2", 1, 3'd3, 3'd2, 0, 1, REJ_NONE);
    for (int i = 0; i < 4; i++) cycle("drain c", 0, 3'd0, 3'd0, 0, 1, REJ_NONE);

    // Reset with three held entries and a strobe in the reset cycle.
    cycle("pre 0->1", 1, 3'd0, 3'd1, 1, 0, REJ_NONE);
    cycle("pre 2->0", 1, 3'd2, 3'd0, 0, 0, REJ_NONE);
    cycle("pre 4->7", 1, 3'd4, 3'd7, 1, 0, REJ_NONE);
    rst_n    = 1'b0;
    req_stb  = 1'b1;
    req_src  = 3'd6;
    req_dest = 3'd7;
    req_dir  = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    req_stb = 1'b0;
    chk("post-rst reject", 8'(reject), 8'h0);
    chk("post-rst reject_code", 8'(reject_code), 8'h0);
    chk_state("post-rst");
    cycle("post-rst idle", 0, 3'd0, 3'd0, 0, 1, REJ_NONE);
    cycle("post-rst 6->7", 1, 3'd6, 3'd7, 1, 0, REJ_NONE);
    cycle("post-rst pop", 0, 3'd0, 3'd0, 0, 1, REJ_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_request_queue.md
Name: elevator_request_queue

Overview:
- Upstream stage of the elevator controller. Captures passenger requests (source floor, destination floor, direction) from the call-panel strobe, validates them and discards duplicates.
- Buffers accepted requests in a small in-order FIFO and presents the oldest to the controller over a valid/ready handshake.
- Replaces direct drive of the controller's src/dest/direction inputs by the panel, so requests made while the car is busy are never lost.

Parameters:
- FLOOR_W, 3, floor index width (floors 0..2^FLOOR_W-1)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_stb  in  1  one-cycle request strobe from call panel
- req_src  in  FLOOR_W  pickup floor
- req_dest  in  FLOOR_W  drop-off floor
- req_dir  in  1  1 = up, 0 = down
- out_valid  out  1  head entry available
- out_ready  in  1  controller can take a request this cycle
- out_src  out  FLOOR_W  head pickup floor
- out_dest  out  FLOOR_W  head drop-off floor
- out_dir  out  1  head direction
- count  out  $clog2(DEPTH)+1  entries held
- full  out  1  count == DEPTH
- reject  out  1  one-cycle pulse: last strobe not enqueued
- reject_code  out  2  reason, valid while reject = 1

Behaviour:
- Reset (rst_n low at a clk edge):
  - Pointers and count cleared.
  - out_valid = 0, full = 0, reject = 0, reject_code = 0.
  - out_src/out_dest/out_dir = 0.
  - Contents not cleared; entries are invalid via count.
  - Reset mid-operation discards all pending requests. A strobe in the reset cycle is ignored.
- State is pointers plus count; no FSM beyond the FIFO occupancy.
- Pop: out_valid && out_ready at an edge. Head is removed and out_* shows the next entry from the following cycle. out_* is held stable while out_valid && !out_ready.
- Push: req_stb at edge N. Checks are evaluated in priority order; the first match rejects:
  - Code 1, invalid: req_src == req_dest, or req_dir != (req_dest > req_src).
  - Code 2, duplicate: identical {src, dest, dir} already held in a valid entry. The head entry being popped in the same cycle is excluded from the comparison.
  - Code 3, full: count == DEPTH and no pop in the same cycle.
- On accept: written at the tail, count increments, reject = 0 at N+1. If the queue was empty, out_valid = 1 and out_* shows the entry at N+1 (1-cycle latency).
- On reject: no state change; reject = 1 with its code for exactly cycle N+1.
- Simultaneous push and pop:
  - count unchanged and both pointers advance.
  - Full + pop + valid push is accepted.
  - Empty + push: no pop is possible because out_valid = 0.
- Pointers wrap modulo DEPTH. count saturates by construction and never exceeds DEPTH or underflows.
- out_ready while empty is ignored.
- reject_code returns to 0 in any cycle without a reject.

Decomposition:
- elevator_pkg holds:
  - FLOOR_W
  - a request struct {src, dest, dir}
  - reject code constants REJ_NONE = 0, REJ_INVALID = 1, REJ_DUP = 2, REJ_FULL = 3
- The controller imports the same package.
- One natural sub-module: req_fifo, a generic register FIFO with push/pop/count/full and parallel read of all entries for the duplicate compare.
- Validation and duplicate logic stay in elevator_request_queue.

Test Plan:
- Reset, then strobe 2->5 up with out_ready = 0:
  - Cycle N+1: out_valid = 1, out_src = 2, out_dest = 5, out_dir = 1, count = 1, reject = 0.
- Strobes 3->3 up, then 4->3 up:
  - Each gives a reject pulse with code 1; count unchanged.
- Enqueue 2->5 up, then strobe 2->5 up again:
  - reject = 1, code 2, count = 1.
  - Repeat the duplicate strobe in the cycle the head pops: accepted, count = 1.
- Fill 4 distinct requests (1->2, 2->3, 3->4, 4->5):
  - full = 1.
  - Fifth strobe 5->6 with out_ready = 0: reject code 3.
  - Same strobe with out_ready = 1: accepted, count stays 4, head becomes 2->3.
- Push 6 requests interleaved with pops across the wrap:
  - out_* order matches push order; count returns to 0; out_valid = 0.
- 3 entries held, assert rst_n = 0 for one cycle together with a strobe:
  - Afterwards count = 0, out_valid = 0, reject = 0; strobed request absent.
